mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_access_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for mem_access_ctrl: FSM state encoding, default
// widths and the burst-length field width.
package mem_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-port synchronous RAM access sequencer.
// Accepts a read or write request, drives the RAM address/data/write-enable
// and returns read data with a two-cycle latency. All outputs are registered.
// Optional feature: define MEM_ACCESS_CTRL_BURST_EN to enable LEN+1 byte
// read bursts with a wrapping address; writes stay single-byte.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              REQ,
    input  logic              RW,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [LEN_W-1:0]  LEN,
    output logic              BUSY,
    output logic [DATA_W-1:0] RDATA,
    output logic              RVALID,
    output logic              DONE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_D,
    output logic              MEM_WE,
    input  logic [DATA_W-1:0] MEM_Q
);

    state_t            state, state_d;
    logic [LEN_W-1:0]  cnt, cnt_d;
    logic              rd_pend, rd_pend_d;
    logic              rw_q, rw_q_d;
    logic              busy_d, rvalid_d, done_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] memd_d, rdata_d;
    logic [LEN_W-1:0]  len_eff;

`ifdef MEM_ACCESS_CTRL_BURST_EN
    assign len_eff = RW ? '0 : LEN;
`else
    logic unused_len;
    assign unused_len = ^LEN;
    assign len_eff    = '0;
`endif

    // Next-state and next-output logic; rd_pend marks that the RAM sampled a
    // read address at the previous edge, so MEM_Q now holds that byte.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        rd_pend_d = 1'b0;
        rw_q_d    = rw_q;
        busy_d    = BUSY;
        rvalid_d  = 1'b0;
        done_d    = 1'b0;
        we_d      = 1'b0;
        addr_d    = MEM_ADDR;
        memd_d    = MEM_D;
        rdata_d   = RDATA;

        if (rd_pend) begin
            rdata_d  = MEM_Q;
            rvalid_d = 1'b1;
        end

        case (state)
            ST_IDLE, ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (REQ) begin
                    addr_d  = ADDR;
                    memd_d  = WDATA;
                    we_d    = RW;
                    rw_q_d  = RW;
                    cnt_d   = len_eff;
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rd_pend_d = !rw_q;
                if (rw_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = MEM_ADDR + ADDR_W'(1);
                    cnt_d  = cnt - LEN_W'(1);
                end
            end
            ST_DRAIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rd_pend  <= 1'b0;
            rw_q     <= 1'b0;
            BUSY     <= 1'b0;
            RVALID   <= 1'b0;
            DONE     <= 1'b0;
            MEM_WE   <= 1'b0;
            MEM_ADDR <= '0;
            MEM_D    <= '0;
            RDATA    <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            rd_pend  <= rd_pend_d;
            rw_q     <= rw_q_d;
            BUSY     <= busy_d;
            RVALID   <= rvalid_d;
            DONE     <= done_d;
            MEM_WE   <= we_d;
            MEM_ADDR <= addr_d;
            MEM_D    <= memd_d;
            RDATA    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a registered-read RAM model
// and a read-data scoreboard. Burst checks are built when
// MEM_ACCESS_CTRL_BURST_EN is defined; otherwise the single-read LEN check.
module tb_mem_access_ctrl;

    logic       CLOCK = 1'b0;
    logic       RESET, REQ, RW;
    logic [4:0] ADDR;
    logic [7:0] WDATA;
    logic [1:0] LEN;
    logic       BUSY, RVALID, DONE, MEM_WE;
    logic [7:0] RDATA, MEM_D, MEM_Q;
    logic [4:0] MEM_ADDR;

    logic [7:0] mem [32];

    int total = 0;
    int bad   = 0;
    int we_cnt = 0, done_cnt = 0, rv_cnt = 0;
    logic [7:0] exp_q [$];

    int we0, d0, r0;

    mem_access_ctrl #(.ADDR_W(5), .DATA_W(8)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .REQ(REQ), .RW(RW), .ADDR(ADDR),
        .WDATA(WDATA), .LEN(LEN), .BUSY(BUSY), .RDATA(RDATA),
        .RVALID(RVALID), .DONE(DONE), .MEM_ADDR(MEM_ADDR), .MEM_D(MEM_D),
        .MEM_WE(MEM_WE), .MEM_Q(MEM_Q)
    );

    always #5 CLOCK = ~CLOCK;

    // RAM model: write when MEM_WE=1, otherwise registered read.
    always @(posedge CLOCK) begin
        if (MEM_WE) mem[MEM_ADDR] <= MEM_D;
        else        MEM_Q <= mem[MEM_ADDR];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: activity counters and scoreboard pop on RVALID.
    always @(negedge CLOCK) begin
        if (MEM_WE === 1'b1) we_cnt++;
        if (DONE === 1'b1) done_cnt++;
        if (RVALID === 1'b1) begin
            rv_cnt++;
            if (exp_q.size() == 0) chk("rvalid_unexpected", exp_q.size(), 1);
            else chk("rdata", RDATA, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic drive(input logic rw, input logic [4:0] a, input logic [7:0] d, input logic [1:0] l);
        REQ = 1'b1; RW = rw; ADDR = a; WDATA = d; LEN = l;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  BUSY,     0);
        chk({tag, "_rv"},    RVALID,   0);
        chk({tag, "_done"},  DONE,     0);
        chk({tag, "_we"},    MEM_WE,   0);
        chk({tag, "_maddr"}, MEM_ADDR, 0);
        chk({tag, "_md"},    MEM_D,    0);
        chk({tag, "_rdata"}, RDATA,    0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[5'h00] = 8'h80;
        mem[5'h01] = 8'h3E;
        mem[5'h05] = 8'h7F;
        mem[5'h1F] = 8'h00;
        RESET = 1'b1; REQ = 1'b0; RW = 1'b0; ADDR = '0; WDATA = '0; LEN = '0;
        step(); step();
        chk_reset_vals("rst");
        RESET = 1'b0;
        step();

        // Single read of 0x01
        we0 = we_cnt;
        drive(1'b0, 5'h01, 8'h00, 2'd0);
        exp_q.push_back(8'h3E);
        step();                      // edge N
        REQ = 1'b0;
        chk("rd_busyN", BUSY, 1);
        chk("rd_maddr", MEM_ADDR, 5'h01);
        step();                      // edge N+1
        chk("rd_rv_N1", RVALID, 0);
        chk("rd_busyN1", BUSY, 1);
        step();                      // edge N+2
        chk("rd_rv_N2", RVALID, 1);
        chk("rd_done_N2", DONE, 1);
        chk("rd_busyN2", BUSY, 0);
        step();
        chk("rd_rv_N3", RVALID, 0);
        chk("rd_done_N3", DONE, 0);
        chk("rd_we_cnt", we_cnt - we0, 0);

        // Write 0x05=0xA5, then back-to-back read in the DONE cycle
        we0 = we_cnt;
        drive(1'b1, 5'h05, 8'hA5, 2'd0);
        step();                      // edge N
        REQ = 1'b0;
        chk("wr_we", MEM_WE, 1);
        chk("wr_md", MEM_D, 8'hA5);
        chk("wr_maddr", MEM_ADDR, 5'h05);
        chk("wr_busy", BUSY, 1);
        step();                      // edge N+1
        chk("wr_we_off", MEM_WE, 0);
        chk("wr_done", DONE, 1);
        chk("wr_busy_off", BUSY, 0);
        chk("wr_rv", RVALID, 0);
        drive(1'b0, 5'h05, 8'h00, 2'd0);
        exp_q.push_back(8'hA5);
        step();                      // read accepted
        REQ = 1'b0;
        chk("b2b_busy", BUSY, 1);
        chk("b2b_done_off", DONE, 0);
        step(); step();
        chk("b2b_rv", RVALID, 1);
        step();
        chk("wr_we_cnt", we_cnt - we0, 1);

        // REQ held while BUSY must be ignored
        d0 = done_cnt; r0 = rv_cnt;
        drive(1'b0, 5'h01, 8'h00, 2'd0);
        exp_q.push_back(8'h3E);
        step();                      // edge N
        drive(1'b0, 5'h00, 8'h00, 2'd0);
        step();                      // edge N+1 (busy)
        step();                      // edge N+2 (busy, completes)
        REQ = 1'b0;
        chk("ign_rv", RVALID, 1);
        step();
        chk("ign_busy", BUSY, 0);
        step(); step(); step();
        chk("ign_done_cnt", done_cnt - d0, 1);
        chk("ign_rv_cnt", rv_cnt - r0, 1);

        // Reset the cycle after a read is accepted
        d0 = done_cnt; r0 = rv_cnt;
        drive(1'b0, 5'h01, 8'h00, 2'd0);
        step();                      // accepted
        REQ = 1'b0;
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk_reset_vals("abort");
        step(); step(); step();
        chk("abort_done_cnt", done_cnt - d0, 0);
        chk("abort_rv_cnt", rv_cnt - r0, 0);
        drive(1'b0, 5'h00, 8'h00, 2'd0);
        exp_q.push_back(8'h80);
        step();
        REQ = 1'b0;
        step(); step(); step();

        // Write whose MEM_WE cycle ends at the reset edge still lands
        drive(1'b1, 5'h02, 8'h5A, 2'd0);
        step();
        REQ = 1'b0;
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("wrst_we", MEM_WE, 0);
        drive(1'b0, 5'h02, 8'h00, 2'd0);
        exp_q.push_back(8'h5A);
        step();
        REQ = 1'b0;
        step(); step(); step();

`ifdef MEM_ACCESS_CTRL_BURST_EN
        // Burst read 0x1F, LEN=2, wrapping
        d0 = done_cnt; r0 = rv_cnt;
        drive(1'b0, 5'h1F, 8'h00, 2'd2);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h3E);
        step();                      // edge N
        REQ = 1'b0;
        step();                      // N+1
        chk("bu_rv_N1", RVALID, 0);
        step();                      // N+2
        chk("bu_rv_N2", RVALID, 1);
        chk("bu_done_N2", DONE, 0);
        step();                      // N+3
        chk("bu_rv_N3", RVALID, 1);
        chk("bu_busy_N3", BUSY, 1);
        step();                      // N+4
        chk("bu_rv_N4", RVALID, 1);
        chk("bu_done_N4", DONE, 1);
        chk("bu_busy_N4", BUSY, 0);
        step(); step();
        chk("bu_rv_cnt", rv_cnt - r0, 3);
        chk("bu_done_cnt", done_cnt - d0, 1);
`else
        // LEN ignored without burst support
        r0 = rv_cnt;
        drive(1'b0, 5'h05, 8'h00, 2'd3);
        exp_q.push_back(8'hA5);
        step();                      // edge N
        REQ = 1'b0;
        step();
        step();                      // N+2
        chk("len_busy_N2", BUSY, 0);
        chk("len_rv_N2", RVALID, 1);
        step(); step(); step();
        chk("len_rv_cnt", rv_cnt - r0, 1);
`endif

        step();
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
